// File: rtl/xc_aesmix_pkg.sv
// Shared GF(2^8) helpers and coefficient tables for the lane-parallel
// AES MixColumns / InvMixColumns unit.
package xc_aesmix_pkg;

  // Coefficient row applied to b(i), b(i+1), b(i+2), b(i+3); index 0 is b(i).
  typedef logic [0:3][3:0] coef_t;

  localparam coef_t ENC_COEF = {4'h2, 4'h3, 4'h1, 4'h1};
  localparam coef_t DEC_COEF = {4'he, 4'hb, 4'hd, 4'h9};

  function automatic logic [7:0] xtime2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] xtime3(input logic [7:0] a);
    return xtime2(a) ^ a;
  endfunction

  // Multiply by any 4-bit constant: sum of a*2^i over the set bits of coef4.
  function automatic logic [7:0] xtimeN(input logic [7:0] a, input logic [3:0] coef4);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (coef4[i]) acc = acc ^ p;
      p = xtime2(p);
    end
    return acc;
  endfunction

  function automatic bit lanes_ok(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

// File: rtl/xc_aesmix_byte.sv
// One output byte of (Inv)MixColumns: rotate the column so byte idx sits at
// position 0, then weight the four bytes by the selected coefficient row.
module xc_aesmix_byte
  import xc_aesmix_pkg::*;
(
  input  logic [31:0] column,
  input  logic [1:0]  idx,
  input  logic        enc,
  output logic [7:0]  r
);

  logic [31:0] rot;
  coef_t       c;

  assign rot = 32'({column, column} >> {idx, 3'b000});
  assign c   = enc ? ENC_COEF : DEC_COEF;

  assign r = xtimeN(rot[7:0],   c[0]) ^ xtimeN(rot[15:8],  c[1]) ^
             xtimeN(rot[23:16], c[2]) ^ xtimeN(rot[31:24], c[3]);

endmodule

// File: rtl/xc_aesmix_lanes.sv
// AES (Inv)MixColumns on one column, LANES result bytes per cycle, with an
// optional fully registered result (OUT_REG=1).
module xc_aesmix_lanes
  import xc_aesmix_pkg::*;
#(
  parameter int LANES   = 4,
  parameter bit OUT_REG = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_data,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  localparam int STEPS = 4 / LANES;
  // Step in which ready fires: last compute step, or one past it when registered.
  localparam int LAST  = OUT_REG ? STEPS : STEPS - 1;

  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("xc_aesmix_lanes: LANES must be 1, 2 or 4");
  end

  logic [2:0]             step_q, step_d;
  logic [31:0]            column;
  logic [LANES-1:0][7:0]  lane_r;
  logic [3:0][7:0]        res_b;
  logic                   unused_ok;

  assign column    = {rs2[31:16], rs1[15:0]};
  assign unused_ok = ^{rs1[31:16], rs2[15:0], flush_data[31:8]};

  assign ready = valid && !flush && !reset && (step_q == 3'(LAST));

  always_comb begin
    step_d = '0;
    if (valid && !flush && !ready) step_d = step_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) step_q <= '0;
    else       step_q <= step_d;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] idx;
    assign idx = 2'(step_q[1:0] * 2'(LANES)) + 2'(l);

    xc_aesmix_byte u_byte (
      .column (column),
      .idx    (idx),
      .enc    (enc),
      .r      (lane_r[l])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_byte
    localparam int S = k / LANES;
    localparam int L = k % LANES;
    // Without OUT_REG the final step's bytes go straight to the output unstored.
    localparam bit STORE = OUT_REG || (S < STEPS - 1);

    logic       sel;
    logic [7:0] b_q, b_d;

    assign sel = (step_q == 3'(S));

    always_comb begin
      b_d = b_q;
      if (flush)                        b_d = flush_data[7:0];
      else if (STORE && valid && sel)   b_d = lane_r[L];
    end

    always_ff @(posedge clock) begin
      if (reset) b_q <= '0;
      else       b_q <= b_d;
    end

    assign res_b[k] = (!OUT_REG && sel) ? lane_r[L] : b_q;
  end

  assign result = (OUT_REG || valid) ? res_b : 32'h0;

endmodule

// File: tb/tb_xc_aesmix_lanes.sv
// Self-checking bench: all six LANES x OUT_REG configurations, directed
// vectors plus random columns checked against a plain GF(2^8) matrix model.
module tb_xc_aesmix_lanes;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] col, input bit e);
    int m [4];
    logic [7:0]  r;
    logic [31:0] out;
    if (e) m = '{2, 3, 1, 1};
    else   m = '{14, 11, 13, 9};
    out = '0;
    for (int i = 0; i < 4; i++) begin
      r = '0;
      for (int j = 0; j < 4; j++) r = r ^ gmul(8'(m[j]), col[8*((i+j)%4) +: 8]);
      out[8*i +: 8] = r;
    end
    return out;
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_cfg
    localparam int PL = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;
    localparam bit PO = (g >= 3);
    localparam int S  = 4 / PL;
    localparam int RC = S - 1 + int'(PO);

    logic        reset, flush, valid, enc, ready;
    logic [31:0] flush_data, rs1, rs2, result;

    xc_aesmix_lanes #(.LANES(PL), .OUT_REG(PO)) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .flush_data (flush_data),
      .valid      (valid),
      .rs1        (rs1),
      .rs2        (rs2),
      .enc        (enc),
      .ready      (ready),
      .result     (result)
    );

    function automatic string nm(input string t);
      return $sformatf("L%0d/O%0d %s", PL, PO, t);
    endfunction

    task automatic init();
      reset = 1'b1; flush = 1'b0; flush_data = '0;
      valid = 1'b0; enc = 1'b0; rs1 = '0; rs2 = '0;
    endtask

    // One operation; ready must appear exactly in cycle RC and nowhere before.
    task automatic op(input string t, input logic [31:0] a, input logic [31:0] b,
                      input logic e, input logic [31:0] exp, input bit hold);
      valid = 1'b1; rs1 = a; rs2 = b; enc = e;
      for (int c = 0; c <= RC; c++) begin
        @(negedge clock);
        chk(nm({t, " ready"}), 32'(ready), 32'(c == RC));
        if (c == RC) chk(nm({t, " result"}), result, exp);
        tick();
      end
      if (!hold) begin
        valid = 1'b0;
        @(negedge clock);
        chk(nm({t, " idle ready"}), 32'(ready), 32'h0);
        chk(nm({t, " idle result"}), result, PO ? exp : 32'h0);
        tick();
      end
    endtask

    // Run valid for n cycles with no ready expected.
    task automatic busy(input string t, input int n);
      valid = 1'b1; rs1 = $urandom; rs2 = $urandom; enc = 1'($urandom_range(0, 1));
      for (int c = 0; c < n; c++) begin
        @(negedge clock);
        chk(nm({t, " busy ready"}), 32'(ready), 32'h0);
        tick();
      end
    endtask

    task automatic run();
      int          k;
      logic [31:0] a, b, fd;
      bit          e;
      tick(); tick();
      reset = 1'b0;
      @(negedge clock);
      chk(nm("reset ready"), 32'(ready), 32'h0);
      chk(nm("reset result"), result, 32'h0);
      tick();

      op("t1 enc", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);
      op("t2 dec", 32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db, 1'b0);
      op("t2 enc", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f, 1'b0);

      op("t3 b2b0", 32'hc6c6c6c6, 32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6, 1'b1);
      op("t3 b2b1", 32'h01010101, 32'h01010101, 1'b0, 32'h01010101, 1'b0);

      k = (RC < 2) ? RC : 2;
      if (k > 0) begin
        busy("t4 abort", k);
        valid = 1'b0;
        @(negedge clock);
        chk(nm("t4 dropped ready"), 32'(ready), 32'h0);
        tick();
        op("t4 retry", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);
      end

      k = (RC < 1) ? RC : 1;
      busy("t5 flush", k);
      fd = {$urandom_range(0, 32'hffffff) & 32'hffffff} << 8 | 32'ha5;
      flush = 1'b1; flush_data = fd;
      @(negedge clock);
      chk(nm("t5 flush ready"), 32'(ready), 32'h0);
      tick();
      flush = 1'b0; valid = 1'b0;
      @(negedge clock);
      chk(nm("t5 post ready"), 32'(ready), 32'h0);
      chk(nm("t5 post result"), result, PO ? 32'ha5a5a5a5 : 32'h0);
      tick();
      op("t5 next", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f, 1'b0);

      busy("t6 reset", k);
      reset = 1'b1;
      @(negedge clock);
      chk(nm("t6 reset ready"), 32'(ready), 32'h0);
      tick();
      reset = 1'b0; valid = 1'b0;
      @(negedge clock);
      chk(nm("t6 post ready"), 32'(ready), 32'h0);
      chk(nm("t6 post result"), result, 32'h0);
      tick();
      op("t6 next", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);

      for (int i = 0; i < 8; i++) begin
        a = $urandom; b = $urandom; e = 1'($urandom_range(0, 1));
        op("rnd", a, b, e, ref_mix({b[31:16], a[15:0]}, e),
           (i < 7) && ($urandom_range(0, 1) == 1));
      end
    endtask
  end

  initial begin
    g_cfg[0].init(); g_cfg[1].init(); g_cfg[2].init();
    g_cfg[3].init(); g_cfg[4].init(); g_cfg[5].init();
    g_cfg[0].run();
    g_cfg[1].run();
    g_cfg[2].run();
    g_cfg[3].run();
    g_cfg[4].run();
    g_cfg[5].run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
